wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of each per-hart retire counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port RegWrite_WB, input, 1, writeback valid from the memory stage.
REQ-005 SHALL have port Waddr_WB, input, 5, destination register.
REQ-006 SHALL have port Wdata_WB, input, 32, writeback data.
REQ-007 SHALL have port mhartID_WB, input, 2, hart owning the writeback.
REQ-008 SHALL have port mhartID_ID, input, 2, hart being decoded.
REQ-009 SHALL have ports Raddr1_ID and Raddr2_ID, input, 5 each, decode source registers.
REQ-010 SHALL have ports Rdata1_ID and Rdata2_ID, output, 32 each, source operand values.
REQ-011 SHALL have port Issue_ID, input, 1, decode issues an instruction that writes IssueRd_ID.
REQ-012 SHALL have port IssueRd_ID, input, 5, destination of the issuing instruction, hart mhartID_ID.
REQ-013 SHALL have ports Busy1_ID and Busy2_ID, output, 1 each, source has an outstanding producer.
REQ-014 SHALL have port Stall_ID, output, 1, decode must hold this cycle.
REQ-015 SHALL have port CountSel, input, 2, hart selected for counter readout.
REQ-016 SHALL have port RetireCount, output, COUNT_W, retire counter of hart CountSel.

Function
REQ-017 SHALL hold 4 harts x 32 registers x 32 bits; register 0 of every hart SHALL always read 0 and SHALL never be written.
REQ-018 SHALL write Wdata_WB to register [mhartID_WB][Waddr_WB] on the rising edge when RegWrite_WB=1 and Waddr_WB!=0.
REQ-019 SHALL drive Rdata1_ID and Rdata2_ID combinationally, with zero-cycle read latency.
REQ-020 SHALL bypass Wdata_WB to a read port when RegWrite_WB=1, mhartID_WB=mhartID_ID, Waddr_WB=Raddr and Raddr!=0.
REQ-021 SHALL keep a busy bit per hart per register; register 0 busy bits SHALL be constant 0.
REQ-022 SHALL set busy[mhartID_ID][IssueRd_ID] on the rising edge when Issue_ID=1, IssueRd_ID!=0 and Stall_ID=0.
REQ-023 SHALL clear busy[mhartID_WB][Waddr_WB] on the rising edge when RegWrite_WB=1.
REQ-024 SHALL leave the bit set when a set and a clear hit the same hart and register in the same cycle (the new producer wins).
REQ-025 SHALL drive each BusyN_ID = busy[mhartID_ID][RaddrN_ID] AND NOT (a same-cycle clear of that hart and register).
REQ-026 SHALL drive Stall_ID = Busy1_ID OR Busy2_ID, combinational.
REQ-027 SHALL increment retire counter [mhartID_WB] by 1 on each rising edge with RegWrite_WB=1, including writes to register 0.
REQ-028 SHALL wrap retire counters modulo 2^COUNT_W, with no saturation and no flag.
REQ-029 SHALL drive RetireCount = counter[CountSel], combinational.
REQ-030 SHALL never let activity on one hart alter the registers, busy bits or counter of another hart.

Reset
REQ-031 SHALL, while Reset=1, immediately clear all registers, busy bits and counters, independent of clk.
REQ-032 SHALL output Rdata1_ID=Rdata2_ID=0, Busy1_ID=Busy2_ID=0, Stall_ID=0 and RetireCount=0 during reset, with RegWrite_WB=0.
REQ-033 SHALL ignore Issue_ID and RegWrite_WB while Reset=1; a reset asserted mid-operation discards all pending busy state.

Verification
REQ-034 SHALL pass this scenario: hart 2 writes x5=0xDEADBEEF, then the next cycle hart 2 reads x5 -> 0xDEADBEEF, and hart 1 reads x5 -> 0.
REQ-035 SHALL pass this scenario: in the same cycle, RegWrite_WB with hart 0, x7=0x1234 and a read of hart 0 x7 on port 2 -> Rdata2_ID=0x1234 (bypass).
REQ-036 SHALL pass this scenario: write x0=0xFFFFFFFF -> x0 reads 0, busy stays 0, and the retire counter for that hart increments by 1.
REQ-037 SHALL pass this scenario: issue hart 3 x9, then read x9 -> Stall_ID=1 until the hart 3 x9 writeback cycle, where Busy=0 and the data is bypassed.
REQ-038 SHALL pass this scenario: in the same cycle, issue and writeback to hart 1 x4 -> busy remains 1 afterwards.
REQ-039 SHALL pass this scenario: preload counter 0 to 0xFFFFFFFF, then one writeback -> 0; assert Reset mid-stall -> Stall_ID=0 and all counters 0 immediately.

Source files
------------

// File: rtl/wb_regfile.sv
// Four-hart register file with writeback bypass, per-register scoreboard busy bits
// and per-hart retire counters; all state clears asynchronously on Reset.
module wb_regfile #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               RegWrite_WB,
   input  logic [4:0]         Waddr_WB,
   input  logic [31:0]        Wdata_WB,
   input  logic [1:0]         mhartID_WB,
   input  logic [1:0]         mhartID_ID,
   input  logic [4:0]         Raddr1_ID,
   input  logic [4:0]         Raddr2_ID,
   output logic [31:0]        Rdata1_ID,
   output logic [31:0]        Rdata2_ID,
   input  logic               Issue_ID,
   input  logic [4:0]         IssueRd_ID,
   output logic               Busy1_ID,
   output logic               Busy2_ID,
   output logic               Stall_ID,
   input  logic [1:0]         CountSel,
   output logic [COUNT_W-1:0] RetireCount
);

   logic [31:0]        regs_q [4][32];
   logic [31:0]        regs_d [4][32];
   logic [31:0]        busy_q [4];
   logic [31:0]        busy_d [4];
   logic [COUNT_W-1:0] cnt_q  [4];
   logic [COUNT_W-1:0] cnt_d  [4];

   logic wr_en;
   logic wr_reg;
   logic same_hart;
   logic clr_hit1;
   logic clr_hit2;
   logic iss_en;

   // Writeback and issue are masked while Reset is high so bypass and busy stay quiet.
   assign wr_en     = RegWrite_WB & ~Reset;
   assign wr_reg    = wr_en & (Waddr_WB != 5'd0);
   assign same_hart = (mhartID_WB == mhartID_ID);
   assign clr_hit1  = wr_en & same_hart & (Waddr_WB == Raddr1_ID);
   assign clr_hit2  = wr_en & same_hart & (Waddr_WB == Raddr2_ID);

   always_comb begin
      Rdata1_ID = regs_q[mhartID_ID][Raddr1_ID];
      Rdata2_ID = regs_q[mhartID_ID][Raddr2_ID];
      if (wr_reg && same_hart && (Waddr_WB == Raddr1_ID)) begin
         Rdata1_ID = Wdata_WB;
      end
      if (wr_reg && same_hart && (Waddr_WB == Raddr2_ID)) begin
         Rdata2_ID = Wdata_WB;
      end
      if (Raddr1_ID == 5'd0) begin
         Rdata1_ID = '0;
      end
      if (Raddr2_ID == 5'd0) begin
         Rdata2_ID = '0;
      end
   end

   // A writeback landing this cycle retires the producer, so it no longer blocks decode.
   assign Busy1_ID = busy_q[mhartID_ID][Raddr1_ID] & ~clr_hit1;
   assign Busy2_ID = busy_q[mhartID_ID][Raddr2_ID] & ~clr_hit2;
   assign Stall_ID = Busy1_ID | Busy2_ID;

   assign iss_en = Issue_ID & ~Reset & (IssueRd_ID != 5'd0) & ~Stall_ID;

   assign RetireCount = cnt_q[CountSel];

   always_comb begin
      regs_d = regs_q;
      if (wr_reg) begin
         regs_d[mhartID_WB][Waddr_WB] = Wdata_WB;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[mhartID_WB][Waddr_WB] = 1'b0;
      end
      // Set after clear: a new producer issued in the retire cycle keeps the bit.
      if (iss_en) begin
         busy_d[mhartID_ID][IssueRd_ID] = 1'b1;
      end
      for (int h = 0; h < 4; h++) begin
         busy_d[h][0] = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         cnt_d[mhartID_WB] = cnt_q[mhartID_WB] + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int h = 0; h < 4; h++) begin
            busy_q[h] <= '0;
            cnt_q[h]  <= '0;
            for (int r = 0; r < 32; r++) begin
               regs_q[h][r] <= '0;
            end
         end
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: driver queues expected outputs, a negedge monitor
// pops and compares them against the DUT.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        Reset;
   logic        RegWrite_WB;
   logic [4:0]  Waddr_WB;
   logic [31:0] Wdata_WB;
   logic [1:0]  mhartID_WB;
   logic [1:0]  mhartID_ID;
   logic [4:0]  Raddr1_ID;
   logic [4:0]  Raddr2_ID;
   logic [31:0] Rdata1_ID;
   logic [31:0] Rdata2_ID;
   logic        Issue_ID;
   logic [4:0]  IssueRd_ID;
   logic        Busy1_ID;
   logic        Busy2_ID;
   logic        Stall_ID;
   logic [1:0]  CountSel;
   logic [31:0] RetireCount;

   logic        w_regwrite;
   logic [1:0]  w_hart;
   logic [1:0]  w_sel;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;
   logic        w_b1;
   logic        w_b2;
   logic        w_st;
   logic [3:0]  w_cnt;

   always #5 clk = ~clk;

   wb_regfile #(.COUNT_W(32)) dut (
      .clk(clk), .Reset(Reset),
      .RegWrite_WB(RegWrite_WB), .Waddr_WB(Waddr_WB), .Wdata_WB(Wdata_WB),
      .mhartID_WB(mhartID_WB), .mhartID_ID(mhartID_ID),
      .Raddr1_ID(Raddr1_ID), .Raddr2_ID(Raddr2_ID),
      .Rdata1_ID(Rdata1_ID), .Rdata2_ID(Rdata2_ID),
      .Issue_ID(Issue_ID), .IssueRd_ID(IssueRd_ID),
      .Busy1_ID(Busy1_ID), .Busy2_ID(Busy2_ID), .Stall_ID(Stall_ID),
      .CountSel(CountSel), .RetireCount(RetireCount)
   );

   // Narrow-counter instance to exercise wraparound in a few cycles.
   wb_regfile #(.COUNT_W(4)) u_wrap (
      .clk(clk), .Reset(Reset),
      .RegWrite_WB(w_regwrite), .Waddr_WB(5'd1), .Wdata_WB(32'd0),
      .mhartID_WB(w_hart), .mhartID_ID(2'd0),
      .Raddr1_ID(5'd0), .Raddr2_ID(5'd0),
      .Rdata1_ID(w_rd1), .Rdata2_ID(w_rd2),
      .Issue_ID(1'b0), .IssueRd_ID(5'd0),
      .Busy1_ID(w_b1), .Busy2_ID(w_b2), .Stall_ID(w_st),
      .CountSel(w_sel), .RetireCount(w_cnt)
   );

   localparam logic [6:0] M_R1 = 7'h01, M_R2 = 7'h02, M_B1 = 7'h04, M_B2 = 7'h08,
                          M_ST = 7'h10, M_CNT = 7'h20, M_CW = 7'h40;

   typedef struct {
      string       name;
      logic [6:0]  mask;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        b1;
      logic        b2;
      logic        st;
      logic [31:0] cnt;
      logic [3:0]  cw;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic expect_out(input string name, input logic [6:0] mask,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic b1, input logic b2, input logic st,
                             input logic [31:0] cnt, input logic [3:0] cw);
      exp_t e;
      e.name = name; e.mask = mask; e.r1 = r1; e.r2 = r2;
      e.b1 = b1; e.b2 = b2; e.st = st; e.cnt = cnt; e.cw = cw;
      sb_q.push_back(e);
   endtask

   task automatic cmp(input string name, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.mask[0]) cmp(mon_e.name, "Rdata1", Rdata1_ID, mon_e.r1);
         if (mon_e.mask[1]) cmp(mon_e.name, "Rdata2", Rdata2_ID, mon_e.r2);
         if (mon_e.mask[2]) cmp(mon_e.name, "Busy1", {31'd0, Busy1_ID}, {31'd0, mon_e.b1});
         if (mon_e.mask[3]) cmp(mon_e.name, "Busy2", {31'd0, Busy2_ID}, {31'd0, mon_e.b2});
         if (mon_e.mask[4]) cmp(mon_e.name, "Stall", {31'd0, Stall_ID}, {31'd0, mon_e.st});
         if (mon_e.mask[5]) cmp(mon_e.name, "RetireCount", RetireCount, mon_e.cnt);
         if (mon_e.mask[6]) cmp(mon_e.name, "WrapCount", {28'd0, w_cnt}, {28'd0, mon_e.cw});
      end
   end

   task automatic idle();
      RegWrite_WB = 1'b0; Waddr_WB = 5'd0; Wdata_WB = 32'd0; mhartID_WB = 2'd0;
      Issue_ID = 1'b0; IssueRd_ID = 5'd0;
      mhartID_ID = 2'd0; Raddr1_ID = 5'd0; Raddr2_ID = 5'd0; CountSel = 2'd0;
   endtask

   task automatic wb(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
      RegWrite_WB = 1'b1; mhartID_WB = h; Waddr_WB = a; Wdata_WB = d;
   endtask

   task automatic rd(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
      mhartID_ID = h; Raddr1_ID = a1; Raddr2_ID = a2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; w_regwrite = 1'b0; w_hart = 2'd0; w_sel = 2'd0;
      idle();
      tick();
      // Reset held: writeback/issue must be ignored and outputs zero.
      wb(2'd2, 5'd5, 32'hDEADBEEF); rd(2'd2, 5'd5, 5'd5);
      Issue_ID = 1'b1; IssueRd_ID = 5'd5; CountSel = 2'd2;
      expect_out("reset", 7'h7F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      Reset = 1'b0; idle();
      rd(2'd2, 5'd5, 5'd0); CountSel = 2'd2;
      expect_out("post_reset", M_R1 | M_B1 | M_ST | M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();

      // Hart isolation on write/read.
      idle(); wb(2'd2, 5'd5, 32'hDEADBEEF); rd(2'd1, 5'd5, 5'd0); CountSel = 2'd2;
      expect_out("wr_h2x5", M_R1 | M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd2, 5'd5, 5'd0); CountSel = 2'd2;
      expect_out("rd_h2x5", M_R1 | M_R2 | M_CNT, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0, 32'd1, 4'd0);
      tick();
      idle(); rd(2'd1, 5'd5, 5'd0);
      expect_out("rd_h1x5", M_R1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();

      // Same-cycle bypass on port 2.
      idle(); wb(2'd0, 5'd7, 32'h00001234); rd(2'd0, 5'd5, 5'd7); CountSel = 2'd0;
      expect_out("bypass_h0x7", M_R1 | M_R2 | M_CNT, 32'd0, 32'h00001234, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd0, 5'd7, 5'd7); CountSel = 2'd0;
      expect_out("rd_h0x7", M_R1 | M_R2 | M_CNT, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0, 32'd1, 4'd0);
      tick();

      // Write to x0: no data, no busy, but counted.
      idle(); wb(2'd1, 5'd0, 32'hFFFFFFFF); rd(2'd1, 5'd0, 5'd0); CountSel = 2'd1;
      expect_out("wr_x0", 7'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd1, 5'd0, 5'd0); CountSel = 2'd1;
      expect_out("rd_x0", 7'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd1, 4'd0);
      tick();

      // Scoreboard: issue hart3 x9, stall until its writeback.
      idle(); rd(2'd3, 5'd0, 5'd0); Issue_ID = 1'b1; IssueRd_ID = 5'd9;
      expect_out("iss_h3x9", M_ST, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd3, 5'd9, 5'd0);
      expect_out("h3_busy", M_B1 | M_ST, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd2, 5'd9, 5'd0);
      expect_out("h2_x9_free", M_B1 | M_ST, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd3, 5'd9, 5'd0); Issue_ID = 1'b1; IssueRd_ID = 5'd10;
      expect_out("h3_stall_iss", M_B1 | M_ST, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 4'd0);
      tick();
      idle(); wb(2'd3, 5'd9, 32'hA5A50009); rd(2'd3, 5'd9, 5'd10);
      expect_out("h3_wb", M_R1 | M_B1 | M_B2 | M_ST, 32'hA5A50009, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd3, 5'd9, 5'd10); CountSel = 2'd3;
      expect_out("h3_after", 7'h3F, 32'hA5A50009, 32'd0, 1'b0, 1'b0, 1'b0, 32'd1, 4'd0);
      tick();

      // Same-cycle issue and retire of hart1 x4: producer wins.
      idle(); wb(2'd1, 5'd4, 32'h00000044); rd(2'd1, 5'd0, 5'd0);
      Issue_ID = 1'b1; IssueRd_ID = 5'd4;
      expect_out("iss_wb_h1x4", M_ST, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd1, 5'd0, 5'd4); CountSel = 2'd1;
      expect_out("h1x4_busy", M_R2 | M_B2 | M_ST | M_CNT, 32'd0, 32'h00000044, 1'b0, 1'b1, 1'b1, 32'd2, 4'd0);
      tick();

      // Reset asserted mid-stall, between clock edges.
      idle(); rd(2'd1, 5'd6, 5'd4); CountSel = 2'd1;
      Reset = 1'b1; wb(2'd0, 5'd3, 32'h00000033); Issue_ID = 1'b1; IssueRd_ID = 5'd6;
      expect_out("rst_mid", 7'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      rd(2'd0, 5'd3, 5'd7); CountSel = 2'd0; Issue_ID = 1'b0;
      expect_out("rst_h0", 7'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      CountSel = 2'd2;
      expect_out("rst_cnt2", M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      CountSel = 2'd3;
      expect_out("rst_cnt3", M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      Reset = 1'b0; idle(); rd(2'd1, 5'd6, 5'd4); CountSel = 2'd0;
      expect_out("post_rst_h1", 7'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      idle(); rd(2'd0, 5'd3, 5'd0);
      expect_out("post_rst_h0x3", M_R1 | M_B1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();

      // Counter wraparound on the 4-bit instance.
      idle(); w_regwrite = 1'b1; w_hart = 2'd0; w_sel = 2'd0;
      for (int i = 0; i < 15; i++) tick();
      expect_out("wrap_pre", M_CW, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd15);
      tick();
      w_regwrite = 1'b0;
      expect_out("wrap_zero", M_CW, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      w_sel = 2'd1;
      expect_out("wrap_h1", M_CW, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
      tick();
      tick();

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
